// File: rtl/ex_muldiv.sv
// rtl/ex_muldiv.sv - iterative RV32M multiply/divide unit for the EX stage
// One bit per cycle: shift-add multiplier and restoring divider sharing a 2*XLEN accumulator.
module ex_muldiv #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_i,
  input  logic [2:0]      func3_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  input  logic [4:0]      rd_addr_i,
  input  logic            flush_i,
  output logic [4:0]      rd_addr_o,
  output logic [XLEN-1:0] rd_data_o,
  output logic            reg_wen_o,
  output logic            hold_flag_o,
  output logic            busy_o
);

  localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        func3_q, func3_d;
  logic [4:0]        rd_q, rd_d;
  logic              neg1_q, neg1_d;
  logic              neg2_q, neg2_d;
  logic [XLEN-1:0]   a_q, a_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic              fast_q, fast_d;

  logic              sgn1, sgn2, n1, n2;
  logic [XLEN-1:0]   mag1, mag2;
  logic              is_div, div_zero, div_ovf;

  assign sgn1     = func3_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b110};
  assign sgn2     = func3_i inside {3'b000, 3'b001, 3'b100, 3'b110};
  assign n1       = sgn1 & op1_i[XLEN-1];
  assign n2       = sgn2 & op2_i[XLEN-1];
  assign mag1     = n1 ? (~op1_i + 1'b1) : op1_i;
  assign mag2     = n2 ? (~op2_i + 1'b1) : op2_i;
  assign is_div   = func3_i[2];
  assign div_zero = is_div && (op2_i == '0);
  assign div_ovf  = is_div && !func3_i[0] && (op1_i == {1'b1, {(XLEN-1){1'b0}}})
                    && (op2_i == '1);

  // Restoring step: accumulator upper half is the partial remainder, lower half
  // collects quotient bits; the dividend is consumed MSB-first by shifting a_q.
  logic [XLEN:0]     dv_sh, dv_diff;
  logic              dv_ge;
  logic [XLEN-1:0]   rem_next;
  logic [2*XLEN-1:0] mul_add;

  assign dv_sh    = {acc_q[2*XLEN-1:XLEN], a_q[XLEN-1]};
  assign dv_diff  = dv_sh - {1'b0, b_q};
  assign dv_ge    = ~dv_diff[XLEN];
  assign rem_next = dv_ge ? dv_diff[XLEN-1:0] : dv_sh[XLEN-1:0];
  assign mul_add  = acc_q + ({{XLEN{1'b0}}, a_q} << cnt_q);

  always_comb begin
    state_d = state_q;
    func3_d = func3_q;
    rd_d    = rd_q;
    neg1_d  = neg1_q;
    neg2_d  = neg2_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    fast_d  = fast_q;

    case (state_q)
      IDLE: begin
        if (valid_i && !flush_i) begin
          func3_d = func3_i;
          rd_d    = rd_addr_i;
          neg1_d  = n1;
          neg2_d  = n2;
          a_d     = mag1;
          b_d     = mag2;
          cnt_d   = '0;
          acc_d   = '0;
          fast_d  = 1'b0;
          state_d = CALC;
          if (div_zero) begin
            fast_d  = 1'b1;
            acc_d   = {{XLEN{1'b0}}, (func3_i[1] ? op1_i : {XLEN{1'b1}})};
            state_d = DONE;
          end else if (div_ovf) begin
            fast_d  = 1'b1;
            acc_d   = {{XLEN{1'b0}}, (func3_i[1] ? {XLEN{1'b0}} : op1_i)};
            state_d = DONE;
          end
        end
      end
      CALC: begin
        if (func3_q[2]) begin
          a_d   = a_q << 1;
          acc_d = {rem_next, acc_q[XLEN-2:0], dv_ge};
        end else if (b_q[cnt_q]) begin
          acc_d = mul_add;
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(XLEN-1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (flush_i) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      func3_q <= '0;
      rd_q    <= '0;
      neg1_q  <= 1'b0;
      neg2_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      fast_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      func3_q <= func3_d;
      rd_q    <= rd_d;
      neg1_q  <= neg1_d;
      neg2_q  <= neg2_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      fast_q  <= fast_d;
    end
  end

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem, result;

  assign prod = (neg1_q ^ neg2_q) ? (~acc_q + 1'b1) : acc_q;
  assign quo  = (neg1_q ^ neg2_q) ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
  assign rem  = neg1_q ? (~acc_q[2*XLEN-1:XLEN] + 1'b1) : acc_q[2*XLEN-1:XLEN];

  always_comb begin
    result = '0;
    if (fast_q) begin
      result = acc_q[XLEN-1:0];
    end else begin
      case (func3_q)
        3'b000:                 result = prod[XLEN-1:0];
        3'b001, 3'b010, 3'b011: result = prod[2*XLEN-1:XLEN];
        3'b100, 3'b101:         result = quo;
        default:                result = rem;
      endcase
    end
  end

  // Writeback is a one-cycle view of DONE; a flush in that cycle kills the strobe.
  assign reg_wen_o   = (state_q == DONE) && !flush_i;
  assign rd_addr_o   = (state_q == DONE) ? rd_q : 5'd0;
  assign rd_data_o   = (state_q == DONE) ? result : '0;
  assign busy_o      = (state_q != IDLE);
  assign hold_flag_o = ((state_q == IDLE) && valid_i && !flush_i) || (state_q == CALC);

endmodule
